// File: rtl/taillight_pkg.sv
// Shared definitions for the tail-light sequencer: mode codes,
// sequencer state encoding, lamp patterns and small helpers.
package taillight_pkg;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_BRAKE = 2'b01;
    localparam logic [1:0] MODE_TURN  = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_S1  = 3'b001;
    localparam logic [2:0] LAMP_S2  = 3'b011;
    localparam logic [2:0] LAMP_ALL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BRAKE = 3'd1,
        ST_S1    = 3'd2,
        ST_S2    = 3'd3,
        ST_S3    = 3'd4,
        ST_S0    = 3'd5
    } state_t;

    function automatic logic is_turn(input state_t s);
        return (s == ST_S1) || (s == ST_S2) ||
               (s == ST_S3) || (s == ST_S0);
    endfunction

    function automatic state_t step(input state_t s);
        case (s)
            ST_S1:   return ST_S2;
            ST_S2:   return ST_S3;
            ST_S3:   return ST_S0;
            ST_S0:   return ST_S1;
            default: return s;
        endcase
    endfunction

    function automatic logic [2:0] turn_pattern(input state_t s);
        case (s)
            ST_S1:   return LAMP_S1;
            ST_S2:   return LAMP_S2;
            ST_S3:   return LAMP_ALL;
            default: return LAMP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/taillight_seq_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1, tick high while count is at its top.
// Ports: clk, rst (async high), clr (sync clear to 0), tick.
module tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/taillight_seq.sv
// Tail-light sequencer: brake / turn / brake+turn lamp patterns.
// Ports: clk, rst (async high), mode[1:0], dir -> lamp_l[2:0], lamp_r[2:0].
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int TICK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       dir,
    output logic [2:0] lamp_l,
    output logic [2:0] lamp_r
);

    logic [1:0] mode_q;
    logic       dir_q;
    logic       seq_dir;
    logic       seq_dir_nxt;
    state_t     state;
    state_t     nxt;
    logic       tick;
    logic       restart;
    logic [2:0] nxt_l;
    logic [2:0] nxt_r;
    logic [2:0] pat;
    logic [2:0] side;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (restart),
        .tick(tick)
    );

    // seq_dir remembers the side the running sequence belongs to,
    // so a dir_q change can be detected and restart the sequence.
    always_comb begin
        restart     = mode_q[1] &&
                      (!is_turn(state) || (dir_q != seq_dir));
        nxt         = state;
        seq_dir_nxt = seq_dir;
        unique case (mode_q)
            MODE_NONE:  nxt = ST_IDLE;
            MODE_BRAKE: nxt = ST_BRAKE;
            MODE_TURN,
            MODE_BOTH: begin
                if (restart) begin
                    nxt         = ST_S1;
                    seq_dir_nxt = dir_q;
                end else if (tick) begin
                    nxt = step(state);
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Lamps are registered alongside the state they describe,
    // giving two cycles from mode input to lamp output.
    always_comb begin
        pat  = turn_pattern(nxt);
        side = mode_q[0] ? LAMP_ALL : LAMP_OFF;
        unique case (1'b1)
            (nxt == ST_IDLE): begin
                nxt_l = LAMP_OFF;
                nxt_r = LAMP_OFF;
            end
            (nxt == ST_BRAKE): begin
                nxt_l = LAMP_ALL;
                nxt_r = LAMP_ALL;
            end
            seq_dir_nxt: begin
                nxt_l = side;
                nxt_r = pat;
            end
            default: begin
                nxt_l = pat;
                nxt_r = side;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_NONE;
            dir_q   <= 1'b0;
            seq_dir <= 1'b0;
            state   <= ST_IDLE;
            lamp_l  <= LAMP_OFF;
            lamp_r  <= LAMP_OFF;
        end else begin
            mode_q  <= mode;
            dir_q   <= dir;
            seq_dir <= seq_dir_nxt;
            state   <= nxt;
            lamp_l  <= nxt_l;
            lamp_r  <= nxt_r;
        end
    end

endmodule

// File: tb/tb_taillight_seq.sv
// Bench for taillight_seq with TICK_DIV=4: per-cycle vector table,
// expected lamps queued on drive and compared after each clock edge.
module tb_taillight_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       dir = 1'b0;
    logic [2:0] lamp_l;
    logic [2:0] lamp_r;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic       dir;
        int         n;
        logic [2:0] el;
        logic [2:0] er;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] el;
        logic [2:0] er;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    taillight_seq #(
        .TICK_DIV(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .dir   (dir),
        .lamp_l(lamp_l),
        .lamp_r(lamp_r)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] m,
                       input logic d, input int n,
                       input logic [2:0] el, input logic [2:0] er);
        vec_t v;
        v.rst = r; v.mode = m; v.dir = d; v.n = n;
        v.el = el; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [2:0] el, input logic [2:0] er);
        checks++;
        if (lamp_l !== el || lamp_r !== er) begin
            failures++;
            $display("FAIL %s vec=%0d t=%0t got l=%b r=%b want l=%b r=%b",
                     name, idx, $time, lamp_l, lamp_r, el, er);
        end
    endtask

    task automatic run_vecs();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                @(negedge clk);
                rst  = vecs[i].rst;
                mode = vecs[i].mode;
                dir  = vecs[i].dir;
                e.idx = i; e.el = vecs[i].el; e.er = vecs[i].er;
                sb.push_back(e);
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty vec=%0d", i);
                end else begin
                    e = sb.pop_front();
                    check("vec", e.idx, e.el, e.er);
                end
            end
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset, then left turn with 4-cycle steps
        add(1, 2'b00, 0, 2, 3'b000, 3'b000);
        add(0, 2'b00, 0, 3, 3'b000, 3'b000);
        add(0, 2'b10, 0, 1, 3'b000, 3'b000);
        add(0, 2'b10, 0, 4, 3'b001, 3'b000);
        add(0, 2'b10, 0, 4, 3'b011, 3'b000);
        add(0, 2'b10, 0, 4, 3'b111, 3'b000);
        add(0, 2'b10, 0, 4, 3'b000, 3'b000);
        add(0, 2'b10, 0, 4, 3'b001, 3'b000);
        add(0, 2'b10, 0, 4, 3'b011, 3'b000);
        add(0, 2'b10, 0, 1, 3'b111, 3'b000);
        // dir flip in left S3: restart on right, 4 cycles per step
        add(0, 2'b10, 1, 1, 3'b111, 3'b000);
        add(0, 2'b10, 1, 4, 3'b000, 3'b001);
        add(0, 2'b10, 1, 3, 3'b000, 3'b011);
        // dir flip landing on the tick cycle: restart wins
        add(0, 2'b10, 0, 1, 3'b000, 3'b011);
        add(0, 2'b10, 0, 4, 3'b001, 3'b000);
        add(0, 2'b10, 0, 1, 3'b011, 3'b000);
        // 10 -> 11 in S2: only the non-turning side changes
        add(0, 2'b11, 0, 1, 3'b011, 3'b000);
        add(0, 2'b11, 0, 1, 3'b011, 3'b111);
        // brake held, then off
        add(0, 2'b01, 0, 1, 3'b011, 3'b111);
        add(0, 2'b01, 0, 6, 3'b111, 3'b111);
        add(0, 2'b00, 0, 1, 3'b111, 3'b111);
        add(0, 2'b00, 0, 3, 3'b000, 3'b000);
        // brake + right, then 11 -> 10 in S2
        add(0, 2'b11, 1, 1, 3'b000, 3'b000);
        add(0, 2'b11, 1, 4, 3'b111, 3'b001);
        add(0, 2'b11, 1, 1, 3'b111, 3'b011);
        add(0, 2'b10, 1, 1, 3'b111, 3'b011);
        add(0, 2'b10, 1, 2, 3'b000, 3'b011);
        add(0, 2'b10, 1, 4, 3'b000, 3'b111);
        add(0, 2'b10, 1, 4, 3'b000, 3'b000);
        add(0, 2'b10, 1, 4, 3'b000, 3'b001);
        add(0, 2'b10, 1, 4, 3'b000, 3'b011);
        add(0, 2'b10, 1, 2, 3'b000, 3'b111);
        run_vecs();

        // async reset mid-S3: lamps clear before the next edge
        #2;
        rst  = 1'b1;
        mode = 2'b00;
        #1;
        check("async_rst", -1, 3'b000, 3'b000);

        add(1, 2'b00, 0, 2, 3'b000, 3'b000);
        add(0, 2'b00, 0, 6, 3'b000, 3'b000);
        // restart after reset: fresh sequence from S1
        add(0, 2'b10, 0, 1, 3'b000, 3'b000);
        add(0, 2'b10, 0, 4, 3'b001, 3'b000);
        add(0, 2'b10, 0, 1, 3'b011, 3'b000);
        run_vecs();

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover n=%0d", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
